// File: rtl/clk_div_prog.sv
// Programmable clock divider: registered clk_out with run-time period/high time and a period-start tick.
// Optional macro CLKDIV_GRACEFUL_STOP_EN lets the current period finish after en falls.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | counter held at 0, clk_out/tick low, pending config applied at once
// S_RUN    | counter cycling 0..div_r-1, outputs follow the counter
// S_STOPPING | (macro only) en dropped, finishing the current period before idle

module clk_div_prog #(
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 5,
  parameter int DEF_HIGH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] HIGH_RST  = CNT_W'(DEF_HIGH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
`ifdef CLKDIV_GRACEFUL_STOP_EN
    S_STOPPING = 2'd2,
`endif
    S_RUN      = 2'd1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_r;
  logic [CNT_W-1:0] high_r;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] pend_high;
  logic [CNT_W-1:0] high_clamped;
  logic             pend;
  logic             at_wrap;
  logic             counting;
  logic             load;
  logic             accept;

  assign at_wrap = (cnt == (div_r - ONE));
  assign accept  = cfg_valid && cfg_ready;
  assign running = (state_q != S_IDLE);

  // High time is forced into 1..div-1 so every period has both phases.
  always_comb begin
    high_clamped = cfg_high;
    if (cfg_high == '0) begin
      high_clamped = ONE;
    end else if (cfg_high >= cfg_div) begin
      high_clamped = cfg_div - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    counting = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        counting = 1'b1;
        if (!en) begin
`ifdef CLKDIV_GRACEFUL_STOP_EN
          state_d = at_wrap ? S_IDLE : S_STOPPING;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef CLKDIV_GRACEFUL_STOP_EN
      S_STOPPING: begin
        counting = 1'b1;
        if (en) begin
          state_d = S_RUN;
        end else if (at_wrap) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
    load = pend && ((state_q == S_IDLE) || (counting && at_wrap));
  end

  // Config staging: cfg_ready mirrors "no config pending".
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_r     <= DIV_RST;
      high_r    <= HIGH_RST;
      pend      <= 1'b0;
      pend_div  <= DIV_RST;
      pend_high <= HIGH_RST;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (load) begin
        div_r     <= pend_div;
        high_r    <= pend_high;
        pend      <= 1'b0;
        cfg_ready <= 1'b1;
      end
      if (accept) begin
        if (cfg_div < TWO) begin
          cfg_err <= 1'b1;
        end else begin
          pend_div  <= cfg_div;
          pend_high <= high_clamped;
          pend      <= 1'b1;
          cfg_ready <= 1'b0;
        end
      end
    end
  end

  // Outputs are registered from the current count, so they trail cnt by one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (counting && (state_d != S_IDLE)) begin
      clk_out <= (cnt < high_r);
      tick    <= (cnt == '0);
      cnt     <= at_wrap ? '0 : (cnt + ONE);
    end else begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: hand-derived vector table applied through a scoreboard queue.
// Test 5 expectations follow CLKDIV_GRACEFUL_STOP_EN when it is defined.

module tb_clk_div_prog;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;
  logic             running;

  always #5 clk = ~clk;

  clk_div_prog #(.CNT_W(CNT_W), .DEF_DIV(5), .DEF_HIGH(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running)
  );

  typedef struct {
    logic             rst_n;
    logic             en;
    logic             cv;
    logic [CNT_W-1:0] cd;
    logic [CNT_W-1:0] ch;
    logic             co;
    logic             tk;
    logic             rdy;
    logic             err;
    logic             run;
  } vec_t;

  typedef struct {
    int   idx;
    logic co;
    logic tk;
    logic rdy;
    logic err;
    logic run;
  } exp_t;

  vec_t table_q[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_step = 0;

  function automatic vec_t mk(input logic r, input logic e, input logic v,
                              input int d, input int h,
                              input logic co, input logic tk, input logic rdy,
                              input logic err, input logic run);
    vec_t t;
    t.rst_n = r;  t.en = e;  t.cv = v;
    t.cd = CNT_W'(d);  t.ch = CNT_W'(h);
    t.co = co;  t.tk = tk;  t.rdy = rdy;  t.err = err;  t.run = run;
    return t;
  endfunction

  task automatic add(input logic r, input logic e, input logic v, input int d, input int h,
                     input logic co, input logic tk, input logic rdy,
                     input logic err, input logic run);
    table_q.push_back(mk(r, e, v, d, h, co, tk, rdy, err, run));
  endtask

  task automatic check1(input int idx, input string name, input logic act, input logic exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %b, want %b", idx, name, act, exp);
    end
  endtask

  // Drive one vector just after a negedge, then compare on the following negedge.
  task automatic step(input vec_t v);
    exp_t e;
    reset_n   = v.rst_n;
    en        = v.en;
    cfg_valid = v.cv;
    cfg_div   = v.cd;
    cfg_high  = v.ch;
    e.idx = n_step;  e.co = v.co;  e.tk = v.tk;  e.rdy = v.rdy;  e.err = v.err;  e.run = v.run;
    sb.push_back(e);
    n_step++;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: got empty queue, want an entry");
    end else begin
      e = sb.pop_front();
      n_vec++;
      check1(e.idx, "clk_out",   clk_out,   e.co);
      check1(e.idx, "tick",      tick,      e.tk);
      check1(e.idx, "cfg_ready", cfg_ready, e.rdy);
      check1(e.idx, "cfg_err",   cfg_err,   e.err);
      check1(e.idx, "running",   running,   e.run);
    end
  endtask

  initial begin
    reset_n = 1'b0;  en = 1'b0;  cfg_valid = 1'b0;  cfg_div = '0;  cfg_high = '0;

    //   rst en cv div high | co tk rdy err run
    // reset
    add(0,0,0,0,0, 0,0,1,0,0);
    add(0,0,0,0,0, 0,0,1,0,0);
    // defaults 5/2: one-cycle latency, then 1,1,0,0,0
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 1,1,1,0,1);
    add(1,1,0,0,0, 1,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 1,1,1,0,1);
    add(1,1,0,0,0, 1,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 1,1,1,0,1);
    // offer 8/4 at cnt=1; old period completes
    add(1,1,1,8,4, 1,0,0,0,1);
    add(1,1,0,0,0, 0,0,0,0,1);
    add(1,1,0,0,0, 0,0,0,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 1,1,1,0,1);
    add(1,1,0,0,0, 1,0,1,0,1);
    add(1,1,0,0,0, 1,0,1,0,1);
    add(1,1,0,0,0, 1,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    // offer div=1: rejected, period stays 8/4
    add(1,1,1,1,0, 1,1,1,1,1);
    add(1,1,0,0,0, 1,0,1,0,1);
    add(1,1,0,0,0, 1,0,1,0,1);
    add(1,1,0,0,0, 1,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 1,1,1,0,1);
    // offer 6/0 -> high clamped to 1
    add(1,1,1,6,0, 1,0,0,0,1);
    add(1,1,0,0,0, 1,0,0,0,1);
    add(1,1,0,0,0, 1,0,0,0,1);
    add(1,1,0,0,0, 0,0,0,0,1);
    add(1,1,0,0,0, 0,0,0,0,1);
    add(1,1,0,0,0, 0,0,0,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 1,1,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    // offer 6/9 on the wrap cycle: waits a full 6/1 period, then high clamped to 5
    add(1,1,1,6,9, 0,0,0,0,1);
    add(1,1,0,0,0, 1,1,0,0,1);
    add(1,1,0,0,0, 0,0,0,0,1);
    add(1,1,0,0,0, 0,0,0,0,1);
    add(1,1,0,0,0, 0,0,0,0,1);
    add(1,1,0,0,0, 0,0,0,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 1,1,1,0,1);
    add(1,1,0,0,0, 1,0,1,0,1);
    add(1,1,0,0,0, 1,0,1,0,1);
    add(1,1,0,0,0, 1,0,1,0,1);
    add(1,1,0,0,0, 1,0,1,0,1);
    add(1,1,0,0,0, 0,0,1,0,1);
    add(1,1,0,0,0, 1,1,1,0,1);

    foreach (table_q[i]) begin
      step(table_q[i]);
    end

    // Reset while 8/4 is pending: defaults return, pending config is lost.
    step(mk(1,1,1,8,4, 1,0,0,0,1));
    step(mk(0,1,0,0,0, 0,0,1,0,0));
    step(mk(1,1,0,0,0, 0,0,1,0,1));
    for (int p = 0; p < 2; p++) begin
      step(mk(1,1,0,0,0, 1,1,1,0,1));
      step(mk(1,1,0,0,0, 1,0,1,0,1));
      step(mk(1,1,0,0,0, 0,0,1,0,1));
      step(mk(1,1,0,0,0, 0,0,1,0,1));
      step(mk(1,1,0,0,0, 0,0,1,0,1));
    end
    step(mk(1,1,0,0,0, 1,1,1,0,1));

    // Drop en at cnt=1 of 5/2.
`ifdef CLKDIV_GRACEFUL_STOP_EN
    step(mk(1,0,0,0,0, 1,0,1,0,1));
    step(mk(1,0,0,0,0, 0,0,1,0,1));
    step(mk(1,0,0,0,0, 0,0,1,0,1));
    step(mk(1,0,0,0,0, 0,0,1,0,0));
`else
    step(mk(1,0,0,0,0, 0,0,1,0,0));
    step(mk(1,0,0,0,0, 0,0,1,0,0));
    step(mk(1,0,0,0,0, 0,0,1,0,0));
    step(mk(1,0,0,0,0, 0,0,1,0,0));
`endif
    step(mk(1,0,0,0,0, 0,0,1,0,0));
    // Re-enable restarts from cnt=0.
    step(mk(1,1,0,0,0, 0,0,1,0,1));
    step(mk(1,1,0,0,0, 1,1,1,0,1));
    step(mk(1,1,0,0,0, 1,0,1,0,1));
    step(mk(1,1,0,0,0, 0,0,1,0,1));

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: got %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
